// File: rtl/matrix_exec_pkg.sv
// matrix_exec_pkg: shared widths, op / writeback-select encodings and FSM states
package matrix_exec_pkg;
    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam int EW   = 8;
    typedef enum logic [1:0] {
        OP_MTRANS = 2'b00,
        OP_MVMUL  = 2'b01,
        OP_MSCALE = 2'b10,
        OP_MSLICE = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        WS_NONE  = 2'b00,
        WS_REG   = 2'b01,
        WS_SLICE = 2'b10,
        WS_MAT   = 2'b11
    } ws_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WB   = 2'b10
    } state_t;
endpackage

// File: rtl/matrix_exec_if.sv
// matrix_exec_if: launch inputs and writeback outputs of the matrix execute unit
//   master: drives start/op/rd/rs1_data/matrix_in, observes busy/done/w_*
//   slave : the execute unit itself
interface matrix_exec_if;
    import matrix_exec_pkg::*;
    logic                  start;
    logic [1:0]            op;
    logic [4:0]            rd;
    logic [XLEN-1:0]       rs1_data;
    logic [N*XLEN-1:0]     matrix_in;
    logic                  busy;
    logic                  done;
    logic [1:0]            w_select;
    logic [4:0]            w_regs_addr;
    logic [XLEN-1:0]       w_regs_data;
    logic [N*XLEN-1:0]     w_matrix_data;
    modport master (
        output start, op, rd, rs1_data, matrix_in,
        input  busy, done, w_select, w_regs_addr, w_regs_data, w_matrix_data
    );
    modport slave (
        input  start, op, rd, rs1_data, matrix_in,
        output busy, done, w_select, w_regs_addr, w_regs_data, w_matrix_data
    );
endinterface

// File: rtl/matrix_exec_row_mac.sv
// matrix_row_mac: mod-2^8 element-wise products of a row with a vector, plus their sum
//   i_row  : four 8-bit matrix elements
//   i_vec  : four 8-bit vector elements
//   o_prod : per-element truncated products (used by MSCALE)
//   o_sum  : dot product mod 2^8 (used by MVMUL)
module matrix_row_mac
    import matrix_exec_pkg::*;
(
    input  logic [XLEN-1:0] i_row,
    input  logic [XLEN-1:0] i_vec,
    output logic [XLEN-1:0] o_prod,
    output logic [EW-1:0]   o_sum
);
    for (genvar j = 0; j < N; j++) begin : g_mul
        assign o_prod[EW*j +: EW] = i_row[EW*j +: EW] * i_vec[EW*j +: EW];
    end
    assign o_sum = o_prod[7:0] + o_prod[15:8] + o_prod[23:16] + o_prod[31:24];
endmodule

// File: rtl/matrix_exec.sv
// matrix_exec: multi-cycle matrix execute unit driving the register-file write port
//   clk, rst : clock, synchronous active-low reset
//   bus      : start/op/rd/rs1_data/matrix_in in; busy/done/w_select/w_regs_* /w_matrix_data out
module matrix_exec
    import matrix_exec_pkg::*;
(
    input  logic clk,
    input  logic rst,
    matrix_exec_if.slave bus
);
    state_t            r_state;
    logic [1:0]        r_cnt;
    op_t               r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rs1;
    logic [N*XLEN-1:0] r_mat;
    logic [N*XLEN-1:0] r_acc;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_sel;
    logic [4:0]        r_addr;
    logic [XLEN-1:0]   r_data;
    logic [N*XLEN-1:0] r_mdata;
    logic [XLEN-1:0]   w_row;
    logic [XLEN-1:0]   w_vec;
    logic [XLEN-1:0]   w_prod;
    logic [EW-1:0]     w_sum;
    logic              w_is_mat;

    assign w_row    = r_mat[XLEN*r_cnt +: XLEN];
    // MSCALE reuses the MAC with the scalar broadcast to every lane
    assign w_vec    = r_op == OP_MSCALE ? {N{r_rs1[EW-1:0]}} : r_rs1;
    assign w_is_mat = r_op == OP_MTRANS || r_op == OP_MSCALE;

    matrix_row_mac u_mac (
        .i_row  (w_row),
        .i_vec  (w_vec),
        .o_prod (w_prod),
        .o_sum  (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MTRANS;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_mat   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sel   <= WS_NONE;
            r_addr  <= '0;
            r_data  <= '0;
            r_mdata <= '0;
        end else begin
            r_done  <= 1'b0;
            r_sel   <= WS_NONE;
            r_addr  <= '0;
            r_data  <= '0;
            r_mdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= op_t'(bus.op);
                        r_rd    <= bus.rd;
                        r_rs1   <= bus.rs1_data;
                        r_mat   <= bus.matrix_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    case (r_op)
                        // row cnt of the source becomes column cnt of the result
                        OP_MTRANS: for (int j = 0; j < N; j++) r_acc[XLEN*j + EW*r_cnt +: EW] <= w_row[EW*j +: EW];
                        OP_MVMUL:  r_acc[EW*r_cnt +: EW] <= w_sum;
                        OP_MSCALE: r_acc[XLEN*r_cnt +: XLEN] <= w_prod;
                        default:   r_acc <= r_acc;
                    endcase
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_state <= S_WB;
                end
                S_WB: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    // MVMUL to x0 is a no-op write but still completes
                    r_sel   <= w_is_mat ? WS_MAT : r_op == OP_MSLICE ? WS_SLICE : r_rd == 5'd0 ? WS_NONE : WS_REG;
                    r_addr  <= r_op == OP_MSLICE ? {3'b0, r_rd[1:0]} : r_op == OP_MVMUL ? r_rd : 5'd0;
                    r_data  <= r_op == OP_MSLICE ? r_rs1 : (r_op == OP_MVMUL && r_rd != 5'd0) ? r_acc[XLEN-1:0] : '0;
                    r_mdata <= w_is_mat ? r_acc : '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.w_select      = r_sel;
    assign bus.w_regs_addr   = r_addr;
    assign bus.w_regs_data   = r_data;
    assign bus.w_matrix_data = r_mdata;
endmodule

// File: tb/tb_matrix_exec.sv
// tb_matrix_exec: scoreboard-driven self-checking bench for matrix_exec
module tb_matrix_exec;
    typedef struct packed {
        logic [1:0]   sel;
        logic [4:0]   addr;
        logic [31:0]  data;
        logic [127:0] mdata;
    } res_t;

    localparam logic [127:0] MAT = {32'hcccccccc, 32'h33333333, 32'haaaaaaaa, 32'h55555555};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    res_t sb[$];

    matrix_exec_if bus();
    matrix_exec dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic res_t model(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] rs1, input logic [127:0] mat);
        res_t e;
        logic [7:0] m [4][4];
        logic [7:0] acc;
        e = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = mat[32*i + 8*j +: 8];
        case (op)
            2'b00: begin
                e.sel = 2'b11;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        e.mdata[32*j + 8*i +: 8] = m[i][j];
            end
            2'b01: begin
                for (int i = 0; i < 4; i++) begin
                    acc = 8'd0;
                    for (int j = 0; j < 4; j++) acc = acc + 8'(m[i][j] * rs1[8*j +: 8]);
                    e.data[8*i +: 8] = acc;
                end
                e.sel  = (rd == 5'd0) ? 2'b00 : 2'b01;
                e.addr = rd;
                if (rd == 5'd0) e.data = '0;
            end
            2'b10: begin
                e.sel = 2'b11;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        e.mdata[32*i + 8*j +: 8] = 8'(m[i][j] * rs1[7:0]);
            end
            default: begin
                e.sel  = 2'b10;
                e.addr = {3'b0, rd[1:0]};
                e.data = rs1;
            end
        endcase
        return e;
    endfunction

    // Caller is positioned just after a posedge; start is sampled on the next one.
    task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] rs1, input logic [127:0] mat,
                          output int lat, output res_t obs, output logic busy0);
        bus.op = op; bus.rd = rd; bus.rs1_data = rs1; bus.matrix_in = mat; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        obs = '0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) begin
                obs = {bus.w_select, bus.w_regs_addr, bus.w_regs_data, bus.w_matrix_data};
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = '0; bus.rd = '0; bus.rs1_data = '0; bus.matrix_in = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.w_select, bus.w_regs_addr, bus.w_regs_data, bus.w_matrix_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sel=%b addr=%h data=%h, required all zero",
                     bus.busy, bus.done, bus.w_select, bus.w_regs_addr, bus.w_regs_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mtrans();
        int lat; res_t obs, e; logic b;
        sb.push_back(model(2'b00, 5'd0, 32'h0, MAT));
        run_op(2'b00, 5'd0, 32'h0, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL mtrans_busy: got %b, required 1", b); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL mtrans_latency: got %0d, required 5", lat); end
        checks++; if (obs !== e) begin errors++; $display("FAIL mtrans_result: got %h, required %h", obs, e); end
        checks++; if (obs.sel !== 2'b11 || obs.mdata !== {4{32'hcc33aa55}}) begin
            errors++; $display("FAIL mtrans_spec: got sel=%b mat=%h, required 11 / cc33aa55 x4", obs.sel, obs.mdata);
        end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.w_select !== 2'b00 || bus.w_matrix_data !== '0) begin
            errors++; $display("FAIL mtrans_after_wb: got done=%b busy=%b sel=%b, required 0/0/00 and data 0", bus.done, bus.busy, bus.w_select);
        end
    endtask

    task automatic test_mvmul();
        int lat; res_t obs, e; logic b;
        sb.push_back(model(2'b01, 5'd5, 32'h01010101, MAT));
        run_op(2'b01, 5'd5, 32'h01010101, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (lat !== 5) begin errors++; $display("FAIL mvmul_latency: got %0d, required 5", lat); end
        checks++; if (obs !== e) begin errors++; $display("FAIL mvmul_result: got %h, required %h", obs, e); end
        checks++; if (obs.sel !== 2'b01 || obs.addr !== 5'd5 || obs.data !== 32'h30cca854) begin
            errors++; $display("FAIL mvmul_spec: got sel=%b addr=%0d data=%h, required 01/5/30cca854", obs.sel, obs.addr, obs.data);
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] v = $urandom;
            logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
            logic [4:0] r = 5'($urandom_range(1, 31));
            sb.push_back(model(2'b01, r, v, m));
            run_op(2'b01, r, v, m, lat, obs, b);
            e = sb.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL mvmul_random%0d: got %h, required %h", k, obs, e); end
        end
    endtask

    task automatic test_mscale();
        int lat; res_t obs, e; logic b;
        sb.push_back(model(2'b10, 5'd0, 32'h00000002, MAT));
        run_op(2'b10, 5'd0, 32'h00000002, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (obs !== e) begin errors++; $display("FAIL mscale_result: got %h, required %h", obs, e); end
        checks++; if (obs.sel !== 2'b11 || obs.mdata !== {32'h98989898, 32'h66666666, 32'h54545454, 32'haaaaaaaa}) begin
            errors++; $display("FAIL mscale_spec: got sel=%b mat=%h", obs.sel, obs.mdata);
        end
        begin
            logic [31:0] s = $urandom;
            logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back(model(2'b10, 5'd3, s, m));
            run_op(2'b10, 5'd3, s, m, lat, obs, b);
            e = sb.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL mscale_random: got %h, required %h", obs, e); end
        end
    endtask

    task automatic test_mslice();
        int lat; res_t obs, e; logic b;
        sb.push_back(model(2'b11, 5'd2, 32'hdeadbeef, MAT));
        run_op(2'b11, 5'd2, 32'hdeadbeef, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (lat !== 5 || obs !== e) begin errors++; $display("FAIL mslice_result: got lat=%0d %h, required 5 %h", lat, obs, e); end
        checks++; if (obs.sel !== 2'b10 || obs.addr !== 5'd2 || obs.data !== 32'hdeadbeef) begin
            errors++; $display("FAIL mslice_spec: got sel=%b addr=%0d data=%h, required 10/2/deadbeef", obs.sel, obs.addr, obs.data);
        end
        sb.push_back(model(2'b11, 5'd30, 32'h12345678, MAT));
        run_op(2'b11, 5'd30, 32'h12345678, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (obs !== e) begin errors++; $display("FAIL mslice_rdmask: got %h, required %h", obs, e); end
        sb.push_back(model(2'b01, 5'd0, 32'h01010101, MAT));
        run_op(2'b01, 5'd0, 32'h01010101, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (lat !== 5 || obs.sel !== 2'b00 || obs !== e) begin
            errors++; $display("FAIL mvmul_rd0: got lat=%0d sel=%b %h, required 5 00 %h", lat, obs.sel, obs, e);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int lat = 0; res_t obs = '0; res_t e;
        sb.push_back(model(2'b01, 5'd7, 32'h04030201, MAT));
        bus.op = 2'b01; bus.rd = 5'd7; bus.rs1_data = 32'h04030201; bus.matrix_in = MAT; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    lat = c;
                    obs = {bus.w_select, bus.w_regs_addr, bus.w_regs_data, bus.w_matrix_data};
                end
            end
            if (c == 1) begin bus.matrix_in = ~MAT; bus.rs1_data = 32'hffffffff; bus.op = 2'b00; bus.rd = 5'd9; end
            bus.start = (c == 2) || (c == 4);
        end
        e = sb.pop_front();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_start_count: got %0d dones, required 1", ndone); end
        checks++; if (lat !== 5 || obs !== e) begin errors++; $display("FAIL snapshot_result: got lat=%0d %h, required 5 %h", lat, obs, e); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: got busy=%b, required 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0; int lat; res_t obs, e; logic b;
        bus.op = 2'b10; bus.rd = 5'd0; bus.rs1_data = 32'h3; bus.matrix_in = MAT; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.w_select !== 2'b00) begin
            errors++; $display("FAIL reset_mid: got busy=%b done=%b sel=%b, required 0/0/00", bus.busy, bus.done, bus.w_select);
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.w_select != 2'b00) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL reset_mid_abandon: got %0d writeback cycles, required 0", ndone); end
        sb.push_back(model(2'b00, 5'd0, 32'h0, MAT));
        run_op(2'b00, 5'd0, 32'h0, MAT, lat, obs, b);
        e = sb.pop_front();
        checks++; if (lat !== 5 || obs !== e) begin errors++; $display("FAIL reset_mid_restart: got lat=%0d %h, required 5 %h", lat, obs, e); end
    endtask

    task automatic test_back_to_back();
        int lat; res_t obs, e; logic b;
        logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back(model(2'b10, 5'd1, 32'h7f, m));
        sb.push_back(model(2'b01, 5'd31, 32'h80ff0102, m));
        run_op(2'b10, 5'd1, 32'h7f, m, lat, obs, b);
        e = sb.pop_front();
        checks++; if (lat !== 5 || obs !== e) begin errors++; $display("FAIL b2b_first: got lat=%0d %h, required 5 %h", lat, obs, e); end
        run_op(2'b01, 5'd31, 32'h80ff0102, m, lat, obs, b);
        e = sb.pop_front();
        checks++; if (b !== 1'b1 || lat !== 5 || obs !== e) begin
            errors++; $display("FAIL b2b_second: got busy=%b lat=%0d %h, required 1 5 %h", b, lat, obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_mtrans();
        test_mvmul();
        test_mscale();
        test_mslice();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
